// File: rtl/microwave_cook_ctrl.sv
// Cook sequencing FSM: keypad digit entry, three-cycle timer load, 1 Hz count
// enable, magnetron drive, pause/cancel and done indication.
//
// state | meaning
// SETUP | collecting digits into the entry buffer
// LOAD  | shifting min, tens, secs into the timer (3 cycles)
// COOK  | magnetron on, prescaler issuing one-second enables
// PAUSE | magnetron off, prescaler frozen
// DONE  | timer expired, waiting for stop or door open

module microwave_cook_ctrl #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] tm_data,
  output logic       tm_load,
  output logic       tm_enable,
  output logic       tm_clearn,
  output logic [3:0] buf_min,
  output logic [3:0] buf_tens,
  output logic [3:0] buf_secs,
  output logic       mag_on,
  output logic       done
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    SETUP,
    LOAD,
    COOK,
    PAUSE,
    DONE
  } state_t;

  state_t        state;
  logic [1:0]    ld_idx;
  logic [PW-1:0] presc;
  logic          digit_ok;
  logic          buf_nz;
  logic [3:0]    tens_clamped;

  assign digit_ok     = (key_digit <= 4'd9);
  assign buf_nz       = (buf_min != 4'd0) || (buf_tens != 4'd0) || (buf_secs != 4'd0);
  assign tens_clamped = (buf_tens > 4'd5) ? 4'd5 : buf_tens;

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= SETUP;
      ld_idx    <= 2'd0;
      presc     <= '0;
      buf_min   <= 4'd0;
      buf_tens  <= 4'd0;
      buf_secs  <= 4'd0;
      tm_data   <= 4'd0;
      tm_load   <= 1'b0;
      tm_enable <= 1'b0;
      tm_clearn <= 1'b0;
      mag_on    <= 1'b0;
      done      <= 1'b0;
    end else begin
      tm_clearn <= 1'b1;
      tm_load   <= 1'b0;
      tm_enable <= 1'b0;
      case (state)
        SETUP: begin
          if (stop) begin
            buf_min   <= 4'd0;
            buf_tens  <= 4'd0;
            buf_secs  <= 4'd0;
            tm_clearn <= 1'b0;
          end else if (start && door_closed && buf_nz) begin
            state   <= LOAD;
            ld_idx  <= 2'd0;
            tm_load <= 1'b1;
            tm_data <= buf_min;
          end else if (key_valid && digit_ok) begin
            buf_min  <= buf_tens;
            buf_tens <= buf_secs;
            buf_secs <= key_digit;
          end
        end
        LOAD: begin
          // Output already shows load ld_idx; prepare the following one.
          case (ld_idx)
            2'd0: begin
              tm_load <= 1'b1;
              tm_data <= tens_clamped;
              ld_idx  <= 2'd1;
            end
            2'd1: begin
              tm_load <= 1'b1;
              tm_data <= buf_secs;
              ld_idx  <= 2'd2;
            end
            default: begin
              state  <= COOK;
              presc  <= '0;
              mag_on <= 1'b1;
            end
          endcase
        end
        COOK: begin
          if (stop || !door_closed) begin
            state  <= PAUSE;
            mag_on <= 1'b0;
          end else if (timer_zero) begin
            state  <= DONE;
            mag_on <= 1'b0;
            done   <= 1'b1;
          end else if (presc == PRESC_MAX) begin
            presc     <= '0;
            tm_enable <= 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        PAUSE: begin
          if (stop) begin
            state     <= SETUP;
            buf_min   <= 4'd0;
            buf_tens  <= 4'd0;
            buf_secs  <= 4'd0;
            tm_clearn <= 1'b0;
          end else if (start && door_closed) begin
            state  <= COOK;
            presc  <= '0;
            mag_on <= 1'b1;
          end
        end
        DONE: begin
          if (stop || !door_closed) begin
            state     <= SETUP;
            buf_min   <= 4'd0;
            buf_tens  <= 4'd0;
            buf_secs  <= 4'd0;
            tm_clearn <= 1'b0;
            done      <= 1'b0;
          end
        end
        default: state <= SETUP;
      endcase
    end
  end

endmodule

// File: doc/microwave_cook_ctrl.md
Name: microwave_cook_ctrl

Overview:
Control FSM that sequences the min/sec-tens/sec-units countdown timer datapath for the oven project.
- Collects three BCD digits from the keypad.
- Shifts them into the timer over three consecutive load cycles.
- Generates the 1 Hz count-enable pulse from the system clock.
- Drives the magnetron while cooking.
- Handles pause, cancel and the done indication.
- Sits between keypad/button debouncers and the timer plus display.

Parameters:
TICKS_PER_SEC, 100, clk cycles per one-second count pulse (must be >= 2)

Ports:
clk  in  1  system clock, all logic on rising edge
clear  in  1  synchronous active-high reset
key_valid  in  1  one-cycle strobe, key_digit valid
key_digit  in  4  BCD digit from keypad
start  in  1  start/resume request (level, sampled each cycle)
stop  in  1  pause/cancel request (level)
door_closed  in  1  1 = door closed
timer_zero  in  1  timer reports all three stages at 0
tm_data  out  4  digit presented to the timer's seconds-units stage
tm_load  out  1  timer load strobe
tm_enable  out  1  timer count-down enable pulse
tm_clearn  out  1  timer clear, active-low
buf_min, buf_tens, buf_secs  out  4 each  entry buffer, for the display in SETUP
mag_on  out  1  magnetron drive
done  out  1  cooking finished indicator

Behaviour:
- Clock and reset: one clock `clk`; reset `clear` is synchronous and active-high.
- Reset values (while clear = 1):
  - state = SETUP.
  - Buffers = 0; prescaler = 0.
  - tm_load = tm_enable = mag_on = done = 0; tm_data = 0.
  - tm_clearn = 0, returning to 1 on the first cycle after clear deasserts.
- All outputs are registered.
- Input priority within a cycle: clear > stop > door_closed = 0 > start > key_valid.
- Timer load protocol: each tm_load cycle shifts the timer one stage, seconds-units to seconds-tens to minutes, and writes tm_data into seconds-units. Three load cycles therefore place min, tens and secs correctly.
- SETUP (buffer entry):
  - key_valid with key_digit <= 9: buf_min <= buf_tens, buf_tens <= buf_secs, buf_secs <= key_digit.
  - Digits > 9 are ignored.
  - stop: clear all buffers and pulse tm_clearn = 0 for 1 cycle.
  - start with door_closed = 1 and buffer non-zero: go to LOAD.
  - start with an all-zero buffer or door open: ignored.
- LOAD (exactly 3 cycles, load index 0..2):
  - tm_load = 1 every cycle.
  - tm_data = buf_min, then min(buf_tens, 5), then buf_secs.
  - A tens digit > 5 is clamped to 5.
  - Inputs are ignored except clear.
  - After the third cycle go to COOK with prescaler = 0.
- COOK:
  - mag_on = 1.
  - Prescaler counts 0..TICKS_PER_SEC-1 and wraps.
  - tm_enable = 1 for exactly 1 cycle each time the prescaler equals TICKS_PER_SEC-1.
  - timer_zero = 1: go to DONE with mag_on = 0 the next cycle. This check takes precedence over a tick in the same cycle, so no enable is issued.
  - stop, or door_closed = 0: go to PAUSE.
- PAUSE:
  - mag_on = 0, tm_enable = 0; the prescaler holds its value.
  - start with door_closed = 1: go to COOK, prescaler reset to 0.
  - stop: go to SETUP, clear buffers and pulse tm_clearn low for 1 cycle.
- DONE:
  - done = 1, mag_on = 0.
  - stop, or door_closed = 0: go to SETUP, clear buffers, tm_clearn pulse, done = 0.
  - start and key_valid are ignored.
- Keys pressed outside SETUP are discarded, not queued.
- clear in any state, including mid-LOAD, returns to SETUP immediately with reset values. The timer is cleared via tm_clearn.
- A held start does not re-trigger LOAD after DONE, because DONE exits only to SETUP.

Test Plan:
- Keys 1,2,5 then start (door closed) -> buffers 1/2/5; 3 cycles of tm_load with tm_data 1, 2, 5; then mag_on = 1 and a tm_enable pulse every TICKS_PER_SEC cycles.
- Keys 0,7,9 then start -> tm_data sequence 0, 5, 9 (tens clamped); key 11 in SETUP -> buffers unchanged.
- In COOK, drop door_closed at mid-prescaler -> PAUSE, mag_on = 0, no enables; close the door and assert start -> first enable exactly TICKS_PER_SEC cycles later.
- In COOK, raise timer_zero on the same cycle as a prescaler tick -> no tm_enable; next cycle done = 1, mag_on = 0; stop -> SETUP, buffers 0, tm_clearn low 1 cycle.
- start with all-zero buffer, or with door open -> stays in SETUP, tm_load never asserted.
- clear asserted during the 2nd LOAD cycle -> next cycle state SETUP, tm_load = 0, tm_clearn = 0, buffers 0.
